sseg_scan_capture: RTL

- Receive-side counterpart of the binary-to-seven-segment decoder path.
- Watches a multiplexed 4-digit seven-segment display bus (anode strobes plus a shared abcdefg segment bus), waits for each digit's pattern to settle, and maps the pattern back to a 4-bit code.
- Assembles a full frame of digits and publishes it with a one-cycle valid pulse.
- Used for display loopback checking and on-board self-test of the display driver.

---
 rtl/sseg_scan_capture.sv | 133 +++++++++++++
 1 files changed

// File: rtl/sseg_scan_capture.sv
// rtl/sseg_scan_capture.sv - seven-segment scan bus capture: debounces each digit, decodes it, publishes whole frames
module sseg_scan_capture #(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_DIG-1:0]   an,
    input  logic [6:0]         sseg,
    output logic [4*N_DIG-1:0] digits,
    output logic [N_DIG-1:0]   err,
    output logic               frame_valid,
    output logic [N_DIG-1:0]   seen
);

    typedef enum logic [1:0] {WAIT, COUNT, LOCKED} state_t;

    localparam logic [7:0] STABLE = 8'(STABLE_CYC);

    state_t           state, state_nxt;
    logic [N_DIG-1:0] s_an;
    logic [6:0]       s_seg;
    logic [7:0]       cnt, cnt_nxt;
    logic             in_valid, changed, capture;
    logic [N_DIG-1:0] seen_nxt;
    logic [3:0]       sh_code [N_DIG];
    logic [N_DIG-1:0] sh_err;
    logic [4:0]       dec;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'b0000001: r = 5'h00;
            7'b1001111: r = 5'h01;
            7'b0010010: r = 5'h02;
            7'b0000110: r = 5'h03;
            7'b1001100: r = 5'h04;
            7'b0100100: r = 5'h05;
            7'b0100000: r = 5'h06;
            7'b0001111: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0000100: r = 5'h09;
            7'b0111000: r = 5'h0F;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    // Count is aligned with the sample now entering s_an/s_seg, so it is the
    // run length of identical samples including the one landing this edge.
    always_comb begin
        in_valid  = $onehot(~an);
        changed   = ({an, sseg} != {s_an, s_seg});
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        case (state)
            WAIT: begin
                if (in_valid) begin
                    state_nxt = COUNT;
                    cnt_nxt   = 8'd1;
                end
            end
            COUNT: begin
                if (!in_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 8'd0;
                end else if (changed) begin
                    cnt_nxt = 8'd1;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                    if (cnt_nxt == STABLE) begin
                        capture   = 1'b1;
                        state_nxt = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (!in_valid) begin
                    state_nxt = WAIT;
                    cnt_nxt   = 8'd0;
                end else if (changed) begin
                    state_nxt = COUNT;
                    cnt_nxt   = 8'd1;
                end
            end
            default: begin
                state_nxt = WAIT;
                cnt_nxt   = 8'd0;
            end
        endcase
    end

    // A capture on the completion edge lands after the clear and opens the next frame.
    always_comb begin
        dec      = decode(s_seg);
        seen_nxt = (&seen) ? '0 : seen;
        if (capture) seen_nxt = seen_nxt | ~s_an;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT;
            s_an        <= '0;
            s_seg       <= '0;
            cnt         <= '0;
            digits      <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
            seen        <= '0;
            sh_err      <= '0;
            for (int i = 0; i < N_DIG; i++) sh_code[i] <= '0;
        end else begin
            state       <= state_nxt;
            s_an        <= an;
            s_seg       <= sseg;
            cnt         <= cnt_nxt;
            seen        <= seen_nxt;
            frame_valid <= &seen;
            if (&seen) begin
                err <= sh_err;
                for (int i = 0; i < N_DIG; i++) digits[4*i +: 4] <= sh_code[i];
            end
            for (int i = 0; i < N_DIG; i++) begin
                if (capture && !s_an[i]) begin
                    sh_code[i] <= dec[3:0];
                    sh_err[i]  <= dec[4];
                end
            end
        end
    end

endmodule
